stream_mux_rr: RTL

Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output stage and valid/ready handshakes on every port. It is the sequential successor to the team's fixed 4:1 32-bit select mux. It arbitrates between channels either by an explicit select input or by round-robin, and optionally holds a grant for a whole multi-beat packet. It sits between multiple producers (e.g. ALU/adder result sources) and a single downstream consumer.

---
 rtl/stream_mux_rr.sv | 135 +++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream mux with explicit-select or round-robin grant.
// Defining STREAM_MUX_PKT_LOCK_EN holds the grant on one channel for a whole multi-beat packet.
module stream_mux_rr #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    localparam int NPAD = 1 << SELW;

    logic [NPAD-1:0]  valid_pad;
    logic [NPAD-1:0]  ready_pad;
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  rr_grant;
    logic             rr_hit;
    logic [SELW:0]    rr_idx;
    logic [SELW-1:0]  grant;
    logic             grant_hit;
    logic             le;
    logic             accept;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;

`ifdef STREAM_MUX_PKT_LOCK_EN
    // lock | meaning
    // 0    | per-beat arbitration by mode/sel
    // 1    | grant pinned to locked_chan until an accept with in_last=1
    logic             lock;
    logic [SELW-1:0]  locked_chan;
`endif

    // Indices at or above N read as not-valid, so sel >= N grants nothing.
    always_comb begin
        valid_pad        = '0;
        valid_pad[N-1:0] = in_valid;
    end

    // Search ptr+1 .. ptr (mod N); first valid channel wins.
    always_comb begin
        rr_hit   = 1'b0;
        rr_grant = ptr;
        rr_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            rr_idx = {1'b0, ptr} + (SELW+1)'(i);
            if (rr_idx >= (SELW+1)'(N))
                rr_idx = rr_idx - (SELW+1)'(N);
            if (!rr_hit && valid_pad[rr_idx[SELW-1:0]]) begin
                rr_hit   = 1'b1;
                rr_grant = rr_idx[SELW-1:0];
            end
        end
    end

    always_comb begin
        grant     = mode ? rr_grant : sel;
        grant_hit = mode ? rr_hit   : valid_pad[sel];
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock) begin
            grant     = locked_chan;
            grant_hit = valid_pad[locked_chan];
        end
`endif
    end

    assign le     = !out_valid || out_ready;
    assign accept = rst_n && le && grant_hit;

    always_comb begin
        ready_pad        = '0;
        ready_pad[grant] = accept;
    end

    assign in_ready = ready_pad[N-1:0];

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (grant == SELW'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
                grant_last = in_last[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
            ptr       <= SELW'(N-1);
        end else begin
            if (le)
                out_valid <= accept;
            if (accept) begin
                out_data <= grant_data;
                out_last <= grant_last;
                out_chan <= grant;
                ptr      <= grant;
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock        <= 1'b0;
            locked_chan <= '0;
        end else if (accept) begin
            if (grant_last) begin
                lock <= 1'b0;
            end else begin
                lock        <= 1'b1;
                locked_chan <= grant;
            end
        end
    end
`endif

endmodule
